// File: rtl/prll_bs_rr_rbtr_6drvrs.sv
`default_nettype none
// ============================================================================
// Module   : prll_bs_rr_rbtr_6drvrs
// Brief    : Round-robin arbiter/sequencer moving one word at a time from a
//            driver FIFO to one (unicast) or all-other (broadcast) drivers.
// Revision : 1.0 - initial release
// ============================================================================
module prll_bs_rr_rbtr_6drvrs #(
   parameter int              BITS      = 32,
   parameter int              DRVRS     = 6,
   parameter int              ID_W      = 8,
   parameter logic [ID_W-1:0] BROADCAST = {ID_W{1'b1}}
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [DRVRS-1:0]      pndng,
   input  logic [DRVRS-1:0]      full,
   input  logic [DRVRS*BITS-1:0] D_pop,
   output logic [DRVRS-1:0]      pop,
   output logic [DRVRS-1:0]      push,
   output logic [BITS-1:0]       D_push,
   output logic                  busy,
   output logic [15:0]           drop_cnt
);

   localparam int PTR_W = (DRVRS > 1) ? $clog2(DRVRS) : 1;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GRANT   = 2'd1,
      DELIVER = 2'd2
   } state_t;

   state_t             state, state_nxt;
   logic [PTR_W-1:0]   rr_ptr, rr_ptr_nxt;
   logic [PTR_W-1:0]   src_q, src_nxt;
   logic [BITS-1:0]    data_q, data_nxt;
   logic [DRVRS-1:0]   mask_q, mask_nxt;
   logic [DRVRS-1:0]   pop_nxt, push_nxt;
   logic [BITS-1:0]    d_push_nxt;
   logic               busy_nxt;
   logic [15:0]        drop_nxt;

   logic [PTR_W-1:0]   winner;
   logic               win_vld;
   logic [PTR_W:0]     cand;
   logic [ID_W-1:0]    dst;

   function automatic logic [DRVRS-1:0] onehot(input logic [PTR_W-1:0] idx);
      onehot = DRVRS'(1) << idx;
   endfunction

   // Search starts just after the last winner so it has lowest priority.
   always_comb begin
      winner  = '0;
      win_vld = 1'b0;
      cand    = '0;
      for (int k = 1; k <= DRVRS; k++) begin
         cand = {1'b0, rr_ptr} + (PTR_W+1)'(k);
         if (cand >= (PTR_W+1)'(DRVRS)) begin
            cand = cand - (PTR_W+1)'(DRVRS);
         end
         if (!win_vld && pndng[cand[PTR_W-1:0]]) begin
            winner  = cand[PTR_W-1:0];
            win_vld = 1'b1;
         end
      end
   end

   assign dst = data_q[BITS-1 -: ID_W];

   always_comb begin
      state_nxt  = state;
      rr_ptr_nxt = rr_ptr;
      src_nxt    = src_q;
      data_nxt   = data_q;
      mask_nxt   = mask_q;
      pop_nxt    = '0;
      push_nxt   = '0;
      d_push_nxt = D_push;
      drop_nxt   = drop_cnt;

      case (state)
         IDLE: begin
            if (win_vld) begin
               state_nxt  = GRANT;
               rr_ptr_nxt = winner;
               src_nxt    = winner;
               data_nxt   = D_pop[winner*BITS +: BITS];
               pop_nxt    = onehot(winner);
            end
         end
         GRANT: begin
            if (dst == BROADCAST) begin
               mask_nxt  = ~onehot(src_q);
               state_nxt = DELIVER;
            end else if (dst < ID_W'(DRVRS)) begin
               mask_nxt  = onehot(dst[PTR_W-1:0]);
               state_nxt = DELIVER;
            end else begin
               if (drop_cnt != 16'hFFFF) begin
                  drop_nxt = drop_cnt + 16'd1;
               end
               state_nxt = IDLE;
            end
         end
         DELIVER: begin
            // All-or-nothing: a single full target holds back the whole push.
            if (~|(mask_q & full)) begin
               push_nxt   = mask_q;
               d_push_nxt = data_q;
               state_nxt  = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase

      busy_nxt = (state_nxt != IDLE);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         rr_ptr   <= PTR_W'(DRVRS-1);
         src_q    <= '0;
         data_q   <= '0;
         mask_q   <= '0;
         pop      <= '0;
         push     <= '0;
         D_push   <= '0;
         busy     <= 1'b0;
         drop_cnt <= '0;
      end else begin
         state    <= state_nxt;
         rr_ptr   <= rr_ptr_nxt;
         src_q    <= src_nxt;
         data_q   <= data_nxt;
         mask_q   <= mask_nxt;
         pop      <= pop_nxt;
         push     <= push_nxt;
         D_push   <= d_push_nxt;
         busy     <= busy_nxt;
         drop_cnt <= drop_nxt;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_prll_bs_rr_rbtr_6drvrs.sv
`default_nettype none
// ============================================================================
// Module   : tb_prll_bs_rr_rbtr_6drvrs
// Brief    : Directed bench for the 6-driver round-robin bus arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_prll_bs_rr_rbtr_6drvrs;

   localparam int BITS  = 32;
   localparam int DRVRS = 6;

   logic                  clk;
   logic                  reset;
   logic [DRVRS-1:0]      pndng;
   logic [DRVRS-1:0]      full;
   logic [DRVRS*BITS-1:0] D_pop;
   logic [DRVRS-1:0]      pop;
   logic [DRVRS-1:0]      push;
   logic [BITS-1:0]       D_push;
   logic                  busy;
   logic [15:0]           drop_cnt;

   int n_assert = 0;
   int n_fail   = 0;

   prll_bs_rr_rbtr_6drvrs dut (
      .clk      (clk),
      .reset    (reset),
      .pndng    (pndng),
      .full     (full),
      .D_pop    (D_pop),
      .pop      (pop),
      .push     (push),
      .D_push   (D_push),
      .busy     (busy),
      .drop_cnt (drop_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic set_word(input int idx, input logic [31:0] w);
      D_pop[idx*BITS +: BITS] = w;
   endtask

   initial begin
      reset = 1'b1;
      pndng = '0;
      full  = '0;
      D_pop = '0;
      tick();
      tick();
      chk("rst_pop",  32'(pop), 32'h0);
      chk("rst_push", 32'(push), 32'h0);
      chk("rst_dpush", D_push, 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_drop", 32'(drop_cnt), 32'h0);
      reset = 1'b0;

      // Single unicast from driver 2 to driver 1
      set_word(2, 32'h0100_00AA);
      pndng = 6'b000100;
      tick();
      chk("t1_pop", 32'(pop), 32'h04);
      chk("t1_busy_g", 32'(busy), 32'h1);
      chk("t1_push_g", 32'(push), 32'h0);
      pndng = '0;
      tick();
      chk("t1_pop_off", 32'(pop), 32'h0);
      chk("t1_push_d", 32'(push), 32'h0);
      tick();
      chk("t1_push", 32'(push), 32'h02);
      chk("t1_dpush", D_push, 32'h0100_00AA);
      chk("t1_busy_i", 32'(busy), 32'h0);
      tick();
      chk("t1_push_off", 32'(push), 32'h0);

      // Rotation from reset: all pending, every packet to driver 0
      reset = 1'b1;
      tick();
      reset = 1'b0;
      for (int i = 0; i < DRVRS; i++) set_word(i, 32'h0000_1000 + 32'(i));
      pndng = 6'b111111;
      tick();
      for (int k = 0; k < 7; k++) begin
         chk("t2_pop", 32'(pop), 32'h1 << (k % DRVRS));
         chk("t2_push_g", 32'(push), 32'h0);
         tick();
         chk("t2_pop_d", 32'(pop), 32'h0);
         chk("t2_push_d", 32'(push), 32'h0);
         tick();
         chk("t2_push", 32'(push), 32'h01);
         chk("t2_pop_p", 32'(pop), 32'h0);
         chk("t2_dpush", D_push, 32'h0000_1000 + 32'(k % DRVRS));
         tick();
      end
      pndng = '0;
      tick();
      tick();
      chk("t2_drain_push", 32'(push), 32'h01);
      chk("t2_drain_dpush", D_push, 32'h0000_1001);
      tick();
      chk("t2_idle_busy", 32'(busy), 32'h0);

      // Broadcast from driver 3
      set_word(3, 32'hFF00_1234);
      pndng = 6'b001000;
      tick();
      chk("t3_pop", 32'(pop), 32'h08);
      pndng = '0;
      tick();
      chk("t3_push_d", 32'(push), 32'h0);
      tick();
      chk("t3_push", 32'(push), 32'h37);
      chk("t3_dpush", D_push, 32'hFF00_1234);
      tick();
      chk("t3_push_off", 32'(push), 32'h0);

      // Unicast to driver 4 while its receive FIFO is full
      set_word(4, 32'h0400_BEEF);
      full  = 6'b010000;
      pndng = 6'b010000;
      tick();
      chk("t4_pop", 32'(pop), 32'h10);
      pndng = '0;
      tick();
      for (int c = 0; c < 5; c++) begin
         tick();
         chk("t4_stall_push", 32'(push), 32'h0);
         chk("t4_stall_busy", 32'(busy), 32'h1);
      end
      full = '0;
      tick();
      chk("t4_push", 32'(push), 32'h10);
      chk("t4_dpush", D_push, 32'h0400_BEEF);
      chk("t4_busy", 32'(busy), 32'h0);
      tick();
      chk("t4_push_off", 32'(push), 32'h0);

      // Invalid destination 0x07 is dropped after the pop
      set_word(1, 32'h0700_0001);
      pndng = 6'b000010;
      tick();
      chk("t5_pop", 32'(pop), 32'h02);
      chk("t5_drop0", 32'(drop_cnt), 32'h0);
      pndng = '0;
      tick();
      chk("t5_drop1", 32'(drop_cnt), 32'h1);
      chk("t5_push", 32'(push), 32'h0);
      chk("t5_busy", 32'(busy), 32'h0);
      tick();
      chk("t5_push_after", 32'(push), 32'h0);
      chk("t5_drop_hold", 32'(drop_cnt), 32'h1);

      // Reset while stalled in DELIVER
      set_word(5, 32'h0200_5555);
      full  = 6'b000100;
      pndng = 6'b100000;
      tick();
      chk("t6_pop", 32'(pop), 32'h20);
      pndng = '0;
      tick();
      tick();
      chk("t6_busy_stall", 32'(busy), 32'h1);
      #2;
      reset = 1'b1;
      #1;
      chk("t6_async_busy", 32'(busy), 32'h0);
      chk("t6_async_push", 32'(push), 32'h0);
      chk("t6_async_pop", 32'(pop), 32'h0);
      chk("t6_async_drop", 32'(drop_cnt), 32'h0);
      #1;
      reset = 1'b0;
      full  = '0;
      for (int i = 0; i < DRVRS; i++) set_word(i, 32'h0300_0000 + 32'(i));
      pndng = 6'b111111;
      tick();
      chk("t6_regrant", 32'(pop), 32'h01);
      pndng = '0;
      tick();
      tick();
      chk("t6_push", 32'(push), 32'h08);
      chk("t6_dpush", D_push, 32'h0300_0000);
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire
